// File: rtl/gcd_engine.sv
// Multi-cycle GCD engine with valid/ready handshakes on both sides.
// ALGO=0 runs subtractive Euclid, ALGO=1 runs binary (Stein) with a final shift step.
module gcd_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ALGO  = 1,
  parameter int unsigned CW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CW-1:0]    cycles_out,
  output logic             busy
);

  localparam int unsigned KW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StShift, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] a, b, result;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;

  assign cnt_inc    = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign gcd_out    = result;
  assign cycles_out = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      a         <= '0;
      b         <= '0;
      k         <= '0;
      cnt       <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            a        <= a_in;
            b        <= b_in;
            k        <= '0;
            cnt      <= '0;
            state    <= StCalc;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StCalc: begin
          cnt <= cnt_inc;
          // Zero operands can only be present on entry; both algorithms keep a, b nonzero.
          if (a == '0 || b == '0) begin
            result    <= a | b;
            state     <= StDone;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else if (ALGO == 0) begin
            if (a == b) begin
              result    <= a;
              state     <= StDone;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end else if (a > b) begin
              a <= a - b;
            end else begin
              b <= b - a;
            end
          end else begin
            if (a == b) begin
              state <= StShift;
            end else if (!a[0] && !b[0]) begin
              a <= a >> 1;
              b <= b >> 1;
              k <= k + KW'(1);
            end else if (!a[0]) begin
              a <= a >> 1;
            end else if (!b[0]) begin
              b <= b >> 1;
            end else if (a > b) begin
              a <= a - b;
            end else begin
              b <= b - a;
            end
          end
        end
        StShift: begin
          cnt       <= cnt_inc;
          result    <= a << k;
          state     <= StDone;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width in bits (>=2).
REQ-002 Parameter ALGO, default 1; 0 selects subtractive Euclid, 1 selects binary (Stein).
REQ-003 Parameter CW, default 16, sets the cycle-counter width in bits.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operands a_in/b_in are valid.
REQ-007 in_ready  output  1  engine can accept operands (high only in IDLE).
REQ-008 a_in  input  WIDTH  operand A, unsigned.
REQ-009 b_in  input  WIDTH  operand B, unsigned.
REQ-010 out_valid  output  1  result is valid (high only in DONE).
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 gcd_out  output  WIDTH  GCD result.
REQ-013 cycles_out  output  CW  compute cycles used (CALC plus SHIFT), saturating at 2^CW-1.
REQ-014 busy  output  1  high in CALC or SHIFT.

Function
REQ-015 States SHALL be IDLE, CALC, SHIFT (ALGO=1 only) and DONE.
REQ-016 IDLE: on in_valid&&in_ready, the engine SHALL latch a<=a_in, b<=b_in, k<=0, cnt<=0 and enter CALC on the next edge.
REQ-017 Each CALC cycle SHALL increment cnt, saturating at 2^CW-1.
REQ-018 Zero operands: in the first CALC cycle, if a==0 or b==0, the result SHALL be a|b and the next state DONE; (0,0) gives 0.
REQ-019 ALGO=0, per CALC cycle: if a==b, result<=a and go to DONE; else if a>b, a<=a-b; else b<=b-a.
REQ-020 ALGO=1, per CALC cycle, with the first matching rule applied:
  - a==b: go to SHIFT.
  - both even: a>>=1, b>>=1, k++.
  - a even: a>>=1.
  - b even: b>>=1.
  - both odd: larger <= larger - smaller.
REQ-021 SHIFT SHALL last one cycle, count as one cycle in cnt, set result <= a<<k and go to DONE.
REQ-022 Subtraction SHALL always be larger minus smaller, so no underflow occurs.
REQ-023 k SHALL be wide enough to hold WIDTH-1 without overflow.
REQ-024 DONE: out_valid=1; gcd_out=result and cycles_out=cnt SHALL be held stable until out_valid&&out_ready, then the engine SHALL return to IDLE.
REQ-025 in_ready SHALL be 0 outside IDLE, and in_valid SHALL be ignored outside IDLE.
REQ-026 No accept SHALL occur in the same cycle as result delivery; minimum occupancy is accept, then CALC, then DONE, then IDLE.
REQ-027 Inputs a_in and b_in SHALL be sampled only in the accept cycle; later changes SHALL have no effect.

Reset
REQ-028 Reset SHALL force IDLE and set in_ready=1, out_valid=0, busy=0, gcd_out=0, cycles_out=0, and internal a, b, k and cnt to 0.
REQ-029 Reset asserted in any state, including mid-CALC or DONE with out_ready low, SHALL discard the operation; the engine SHALL be in IDLE on the edge after reset is sampled.
REQ-030 Reset SHALL take priority over every handshake that occurs in the same cycle.

Verification
REQ-031 ALGO=0, WIDTH=16, (48,18) -> gcd_out=6, cycles_out=5, out_valid asserted 6 edges after accept.
REQ-032 ALGO=1, WIDTH=16, (48,18) -> gcd_out=6, cycles_out=8 (7 CALC + 1 SHIFT).
REQ-033 Zero operands: (0,0) -> 0; (0,35) -> 35; (35,0) -> 35; each with cycles_out=1 in both modes.
REQ-034 Backpressure: out_ready held low 10 cycles in DONE -> out_valid, gcd_out and cycles_out stable and in_ready=0 throughout; a single-cycle out_ready pulse returns the engine to IDLE.
REQ-035 ALGO=0, WIDTH=8, (255,1) -> gcd_out=1, cycles_out=255; with CW=4 -> cycles_out=15 (saturated).
REQ-036 Reset pulsed mid-CALC -> out_valid never asserted, in_ready=1 the next cycle; the following accept of (12,8) -> gcd_out=4.
